// File: rtl/glitch_sequencer.sv
`default_nettype none
// ============================================================================
// glitch_sequencer : I2C byte-pattern matcher driving a timed DAC level program
// Revision 1.0 - parametrised successor of the 1.2V-rail substitution core
// ============================================================================
module glitch_sequencer #(
  parameter int              NUM_CH   = 2,
  parameter int              CH_W     = 1,
  parameter int              PKT_W    = 9,
  parameter int              DAC_W    = 8,
  parameter int              OPND_W   = 32,
  parameter int              ADDR_W   = 6,
  parameter logic [DAC_W-1:0] DAC_IDLE = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            i_ch_valid,
  input  logic [NUM_CH*PKT_W-1:0]      i_ch_data,
  input  logic [NUM_CH-1:0]            i_ch_sop,
  input  logic [NUM_CH-1:0]            i_ch_eot,
  input  logic                         i_prog_we,
  input  logic [ADDR_W-1:0]            i_prog_addr,
  input  logic [2+CH_W+OPND_W-1:0]     i_prog_wdata,
  input  logic                         i_arm,
  input  logic                         i_abort,
  input  logic                         i_loop_en,
  output logic [DAC_W-1:0]             o_dac_level,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [ADDR_W-1:0]            o_pc,
  output logic [15:0]                  o_fail_count
);

  localparam int         c_INSTR_W  = 2 + CH_W + OPND_W;
  localparam int         c_DEPTH    = 2 ** ADDR_W;
  localparam logic [1:0] c_OP_MATCH = 2'd0;
  localparam logic [1:0] c_OP_DELAY = 2'd1;
  localparam logic [1:0] c_OP_DAC   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_INSTR_W-1:0]  r_mem [0:c_DEPTH-1];
  logic [c_INSTR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]     r_pc;
  logic [DAC_W-1:0]      r_dac;
  logic [15:0]           r_fail;
  logic [OPND_W-1:0]     r_cnt;
  logic                  r_first;
  logic                  r_arm_d;
  logic                  r_busy;
  logic                  r_done;

  logic [1:0]            w_op;
  logic [CH_W-1:0]       w_ch;
  logic [OPND_W-1:0]     w_opnd;
  logic                  w_sel_valid;
  logic                  w_sel_restart;
  logic [PKT_W-1:0]      w_sel_data;

  assign w_op   = r_instr[c_INSTR_W-1 -: 2];
  assign w_ch   = r_instr[OPND_W +: CH_W];
  assign w_opnd = r_instr[OPND_W-1:0];

  // A channel index with no matching lane leaves every strobe low, so it never matches.
  always_comb begin
    w_sel_valid   = 1'b0;
    w_sel_restart = 1'b0;
    w_sel_data    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == CH_W'(i)) begin
        w_sel_valid   = i_ch_valid[i];
        w_sel_restart = i_ch_sop[i] | i_ch_eot[i];
        w_sel_data    = i_ch_data[i*PKT_W +: PKT_W];
      end
    end
  end

  // Program store is frozen while a sequence runs.
  always_ff @(posedge clk) begin
    if (i_prog_we && (r_state == S_IDLE || r_state == S_DONE))
      r_mem[i_prog_addr] <= i_prog_wdata;
    r_instr <= r_mem[r_pc];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dac   <= DAC_IDLE;
      r_pc    <= '0;
      r_fail  <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_arm_d <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_arm_d <= i_arm;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_dac   <= DAC_IDLE;
        r_pc    <= '0;
        r_cnt   <= '0;
        r_first <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_arm && !r_arm_d) begin
              r_state <= S_FETCH;
              r_pc    <= '0;
              r_busy  <= 1'b1;
            end
          end
          S_FETCH: begin
            r_state <= S_EXEC;
            r_first <= 1'b1;
          end
          S_EXEC: begin
            r_first <= 1'b0;
            case (w_op)
              c_OP_MATCH: begin
                // A packet boundary restarts the pattern and swallows any word in that cycle.
                if (w_sel_restart) begin
                  if (r_pc != '0) begin
                    r_pc    <= '0;
                    r_state <= S_FETCH;
                  end
                end else if (w_sel_valid) begin
                  r_state <= S_FETCH;
                  if (w_sel_data == w_opnd[PKT_W-1:0]) begin
                    r_pc <= r_pc + 1'b1;
                  end else begin
                    r_pc <= '0;
                    if (r_fail != 16'hFFFF)
                      r_fail <= r_fail + 16'd1;
                  end
                end
              end
              c_OP_DELAY: begin
                if (r_first) begin
                  if (w_opnd == '0) begin
                    r_pc    <= r_pc + 1'b1;
                    r_state <= S_FETCH;
                  end else begin
                    r_cnt <= w_opnd - 1'b1;
                  end
                end else if (r_cnt == '0) begin
                  r_pc    <= r_pc + 1'b1;
                  r_state <= S_FETCH;
                end else begin
                  r_cnt <= r_cnt - 1'b1;
                end
              end
              c_OP_DAC: begin
                r_dac   <= w_opnd[DAC_W-1:0];
                r_pc    <= r_pc + 1'b1;
                r_state <= S_FETCH;
              end
              default: begin
                if (i_loop_en) begin
                  r_pc    <= '0;
                  r_state <= S_FETCH;
                end else begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
            endcase
          end
          default: begin
            if (!i_arm) begin
              r_state <= S_IDLE;
              r_done  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign o_dac_level  = r_dac;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pc         = r_pc;
  assign o_fail_count = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_glitch_sequencer : directed stimulus, instruction-level reference model
// Revision 1.0
// ============================================================================
module tb_glitch_sequencer;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int PKT_W  = 9;
  localparam int DAC_W  = 8;
  localparam int OPND_W = 32;
  localparam int ADDR_W = 6;
  localparam int IW     = 2 + CH_W + OPND_W;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_valid, ch_sop, ch_eot;
  logic [NUM_CH*PKT_W-1:0]  ch_data;
  logic                     prog_we;
  logic [ADDR_W-1:0]        prog_addr;
  logic [IW-1:0]            prog_wdata;
  logic                     arm, abort, loop_en;
  logic [DAC_W-1:0]         dac_level;
  logic                     busy, done;
  logic [ADDR_W-1:0]        pc;
  logic [15:0]              fail_count;

  always #5 clk = ~clk;

  glitch_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .PKT_W(PKT_W), .DAC_W(DAC_W),
    .OPND_W(OPND_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .i_ch_valid(ch_valid), .i_ch_data(ch_data), .i_ch_sop(ch_sop), .i_ch_eot(ch_eot),
    .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_wdata(prog_wdata),
    .i_arm(arm), .i_abort(abort), .i_loop_en(loop_en),
    .o_dac_level(dac_level), .o_busy(busy), .o_done(done), .o_pc(pc),
    .o_fail_count(fail_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks the program counter and how many cycles the
  // current instruction has been resident (cycle 0 is its fetch).
  logic [IW-1:0]  m_mem [0:(2**ADDR_W)-1];
  bit             m_busy, m_done, m_arm_prev;
  logic [5:0]     m_pc;
  logic [7:0]     m_dac = 8'hFF;
  int unsigned    m_fail;
  longint         m_el;

  always @(posedge clk) begin : p_model
    logic [1:0]  op;
    logic        ch;
    logic [31:0] opnd;
    bit          adv;
    int          chi;
    if (prog_we && !m_busy) m_mem[prog_addr] = prog_wdata;
    if (reset || abort) begin
      m_busy = 0; m_done = 0; m_pc = 0; m_dac = 8'hFF;
      if (reset) begin m_fail = 0; m_arm_prev = 0; end
      else m_arm_prev = arm;
    end else begin
      if (!m_busy) begin
        if (m_done) begin
          if (!arm) m_done = 0;
        end else if (arm && !m_arm_prev) begin
          m_busy = 1; m_pc = 0; m_el = 0;
        end
      end else if (m_el == 0) begin
        m_el = 1;
      end else begin
        {op, ch, opnd} = m_mem[m_pc];
        chi = int'(ch);
        adv = 0;
        case (op)
          2'd0: if (chi < NUM_CH) begin
            if (ch_sop[chi] || ch_eot[chi]) begin
              if (m_pc != 0) begin m_pc = 0; m_el = 0; end
            end else if (ch_valid[chi]) begin
              if (ch_data[chi*PKT_W +: PKT_W] == opnd[PKT_W-1:0]) adv = 1;
              else begin
                m_pc = 0; m_el = 0;
                if (m_fail < 65535) m_fail++;
              end
            end
          end
          2'd1: if (m_el - 1 == longint'(opnd)) adv = 1; else m_el++;
          2'd2: begin m_dac = opnd[7:0]; adv = 1; end
          default: if (loop_en) begin m_pc = 0; m_el = 0; end
                   else begin m_busy = 0; m_done = 1; end
        endcase
        if (adv) begin m_pc = m_pc + 6'd1; m_el = 0; end
      end
      m_arm_prev = arm;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle {dac,busy,done,pc,fail}",
            {32'd0, dac_level, busy, done, pc, fail_count},
            {32'd0, m_dac, m_busy, m_done, m_pc, 16'(m_fail)});
  end

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic prog(int a, int op, int ch, longint opnd);
    prog_we    = 1'b1;
    prog_addr  = 6'(a);
    prog_wdata = {2'(op), 1'(ch), 32'(opnd)};
    step();
    prog_we    = 1'b0;
  endtask

  task automatic word(int ch, int d);
    ch_valid                     = '0;
    ch_valid[ch]                 = 1'b1;
    ch_data[ch*PKT_W +: PKT_W]   = 9'(d);
    step();
    ch_valid                     = '0;
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && !done; i++) step();
  endtask

  initial begin
    int cnt40, t, t_first, t_second, seen20;
    reset = 1'b1; ch_valid = '0; ch_sop = '0; ch_eot = '0; ch_data = '0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    arm = 1'b0; abort = 1'b0; loop_en = 1'b0;
    step(3);
    chk_en = 1'b1;
    reset  = 1'b0;
    check("reset dac", dac_level, 8'hFF);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pc", pc, 0);
    check("reset fail", fail_count, 0);

    // Pattern 0x1A4,0x0C2 then DAC 0x40, DELAY 10, DAC 0xFF, END.
    prog(0, 0, 0, 'h1A4); prog(1, 0, 0, 'h0C2); prog(2, 2, 0, 'h40);
    prog(3, 1, 0, 10);    prog(4, 2, 0, 'hFF);  prog(5, 3, 0, 0);
    arm = 1'b1; step(3);
    word(0, 'h1A4); step(); word(0, 'h0C2);
    cnt40 = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (dac_level == 8'h40) cnt40++;
    end
    // DELAY fetch + 11 exec cycles, then fetch + exec of the closing DAC.
    check("dac 0x40 duration", cnt40, 14);
    check("p1 done", done, 1);
    check("p1 final dac", dac_level, 8'hFF);

    arm = 1'b0; step();
    check("done cleared on arm low", done, 0);
    arm = 1'b1; step(3);
    word(0, 'h1A4); step(); word(0, 'h0C3);
    check("mismatch fail_count", fail_count, 1);
    check("mismatch pc", pc, 0);
    check("mismatch dac", dac_level, 8'hFF);
    step(); word(0, 'h1A4); step(); word(0, 'h0C2);
    wait_done(100);
    check("rerun done", done, 1);

    // Other-channel words and packet restart.
    arm = 1'b0; reset = 1'b1; step(2); reset = 1'b0;
    arm = 1'b1; step(3);
    word(1, 'h1A4); word(1, 'h0C2);
    check("ch1 ignored pc", pc, 0);
    check("ch1 ignored busy", busy, 1);
    word(0, 'h1A4); step();
    check("first match pc", pc, 1);
    ch_sop = 2'b01; step(); ch_sop = '0;
    check("sop restart pc", pc, 0);
    check("sop restart fail", fail_count, 0);
    abort = 1'b1; step(); abort = 1'b0;
    arm = 1'b0;

    // Loop mode: DAC 0x10; DELAY 0; DAC 0x20; END.
    prog(0, 2, 0, 'h10); prog(1, 1, 0, 0); prog(2, 2, 0, 'h20); prog(3, 3, 0, 0);
    loop_en = 1'b1; arm = 1'b1;
    t_first = -1; t_second = -1; seen20 = 0; t = 0;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] prev;
      prev = dac_level;
      step(); t++;
      if (dac_level == 8'h20) seen20 = 1;
      if (dac_level == 8'h10 && prev != 8'h10) begin
        if (t_first < 0) t_first = t;
        else if (t_second < 0) t_second = t;
      end
    end
    check("loop period", t_second - t_first, 8);
    check("loop saw 0x20", seen20, 1);
    abort = 1'b1; step(); abort = 1'b0;
    loop_en = 1'b0; arm = 1'b0;

    // Abort during a long delay; writes while busy must not land.
    prog(0, 1, 0, 1000); prog(1, 2, 0, 'h55); prog(2, 3, 0, 0);
    arm = 1'b1; step(20);
    check("busy in delay", busy, 1);
    prog(1, 2, 0, 'h99);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort dac", dac_level, 8'hFF);
    check("abort pc", pc, 0);
    prog(0, 1, 0, 0);
    arm = 1'b0; step(); arm = 1'b1;
    wait_done(50);
    check("readback done", done, 1);
    check("readback dac", dac_level, 8'h55);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
